// File: rtl/display_source_arbiter.sv
// display_source_arbiter: shares one 4-digit 7-segment driver between three
// requesters. Round-robin ownership with a minimum dwell per owner, a blank
// gap between different owners, and a free-running scan clock for the driver.
module display_source_arbiter #(
    parameter int unsigned DIV_HALF  = 25000,
    parameter int unsigned DWELL     = 2000000,
    parameter int unsigned BLANK_CYC = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [23:0] data_in,
    output logic [2:0]  gnt,
    output logic [3:0]  unit,
    output logic [3:0]  dec,
    output logic [1:0]  est_maq,
    output logic        disp_en,
    output logic        disp_clk
);

    localparam int unsigned DIV_W   = (DIV_HALF  > 1) ? $clog2(DIV_HALF)  : 1;
    localparam int unsigned DWELL_W = (DWELL     > 1) ? $clog2(DWELL)     : 1;
    localparam int unsigned BLANK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(DIV_HALF - 1);
    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL - 1);
    localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHOW,
        S_BLANK
    } state_t;

    state_t             r_state,  w_nxt_state;
    logic [1:0]         r_ptr,    w_nxt_ptr;
    logic [1:0]         r_owner,  w_nxt_owner;
    logic [2:0]         r_gnt,    w_nxt_gnt;
    logic [3:0]         r_unit,   w_nxt_unit;
    logic [3:0]         r_dec,    w_nxt_dec;
    logic [1:0]         r_est,    w_nxt_est;
    logic               r_en,     w_nxt_en;
    logic [DWELL_W-1:0] r_dwell,  w_nxt_dwell;
    logic [BLANK_W-1:0] r_blank,  w_nxt_blank;
    logic [DIV_W-1:0]   r_div;
    logic               r_dclk;

    logic               w_any;
    logic [1:0]         w_win;
    logic [7:0]         w_win_slice;
    logic [7:0]         w_own_slice;

    function automatic logic [7:0] f_slice(input logic [23:0] d, input logic [1:0] i);
        case (i)
            2'd1:    f_slice = d[15:8];
            2'd2:    f_slice = d[23:16];
            default: f_slice = d[7:0];
        endcase
    endfunction

    // Scan clock divider: toggles disp_clk every DIV_HALF cycles in all states
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_dclk <= 1'b0;
        end else if (r_div == DIV_LAST) begin
            r_div  <= '0;
            r_dclk <= ~r_dclk;
        end else begin
            r_div  <= r_div + 1'b1;
        end
    end

    // Round-robin search: first set request starting at r_ptr, wrapping 2->0
    always_comb begin
        int unsigned idx;
        logic        found;
        w_any = |req;
        w_win = 2'd0;
        found = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            idx = (32'(r_ptr) + k) % 3;
            if (!found && req[idx]) begin
                found = 1'b1;
                w_win = 2'(idx);
            end
        end
        w_win_slice = f_slice(data_in, w_win);
        w_own_slice = f_slice(data_in, r_owner);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_gnt   <= '0;
            r_unit  <= '0;
            r_dec   <= '0;
            r_est   <= '0;
            r_en    <= 1'b0;
            r_dwell <= '0;
            r_blank <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_ptr   <= w_nxt_ptr;
            r_owner <= w_nxt_owner;
            r_gnt   <= w_nxt_gnt;
            r_unit  <= w_nxt_unit;
            r_dec   <= w_nxt_dec;
            r_est   <= w_nxt_est;
            r_en    <= w_nxt_en;
            r_dwell <= w_nxt_dwell;
            r_blank <= w_nxt_blank;
        end
    end

    // Next-state and next-output logic; a grant loads all outputs together
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_ptr   = r_ptr;
        w_nxt_owner = r_owner;
        w_nxt_gnt   = r_gnt;
        w_nxt_unit  = r_unit;
        w_nxt_dec   = r_dec;
        w_nxt_est   = r_est;
        w_nxt_en    = r_en;
        w_nxt_dwell = r_dwell;
        w_nxt_blank = r_blank;

        case (r_state)
            S_SHOW: begin
                if (req[r_owner]) begin
                    w_nxt_unit = w_own_slice[3:0];
                    w_nxt_dec  = w_own_slice[7:4];
                end
                if (r_dwell != '0) begin
                    w_nxt_dwell = r_dwell - 1'b1;
                end else if (!w_any) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_gnt   = '0;
                    w_nxt_est   = '0;
                    w_nxt_en    = 1'b0;
                end else if (w_win == r_owner) begin
                    w_nxt_dwell = DWELL_LOAD;
                    w_nxt_ptr   = (w_win == 2'd2) ? 2'd0 : w_win + 2'd1;
                end else begin
                    w_nxt_state = S_BLANK;
                    w_nxt_gnt   = '0;
                    w_nxt_est   = '0;
                    w_nxt_en    = 1'b0;
                    w_nxt_blank = BLANK_LOAD;
                end
            end
            S_IDLE, S_BLANK: begin
                w_nxt_gnt = '0;
                w_nxt_est = '0;
                w_nxt_en  = 1'b0;
                if (r_state == S_BLANK && r_blank != '0) begin
                    w_nxt_blank = r_blank - 1'b1;
                end else if (w_any) begin
                    w_nxt_state = S_SHOW;
                    w_nxt_owner = w_win;
                    w_nxt_gnt   = 3'b001 << w_win;
                    w_nxt_est   = w_win + 2'd1;
                    w_nxt_unit  = w_win_slice[3:0];
                    w_nxt_dec   = w_win_slice[7:4];
                    w_nxt_en    = 1'b1;
                    w_nxt_dwell = DWELL_LOAD;
                    w_nxt_ptr   = (w_win == 2'd2) ? 2'd0 : w_win + 2'd1;
                end else begin
                    w_nxt_state = S_IDLE;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    assign gnt      = r_gnt;
    assign unit     = r_unit;
    assign dec      = r_dec;
    assign est_maq  = r_est;
    assign disp_en  = r_en;
    assign disp_clk = r_dclk;

endmodule

// File: tb/tb_display_source_arbiter.sv
// Directed bench for display_source_arbiter: the stimulus process drives one
// vector per cycle and queues the outputs expected after that edge; a monitor
// pops and compares just after each rising edge.
module tb_display_source_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [23:0] data_in;
    logic [2:0]  gnt;
    logic [3:0]  unit;
    logic [3:0]  dec;
    logic [1:0]  est_maq;
    logic        disp_en;
    logic        disp_clk;

    display_source_arbiter #(
        .DIV_HALF  (2),
        .DWELL     (4),
        .BLANK_CYC (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .data_in  (data_in),
        .gnt      (gnt),
        .unit     (unit),
        .dec      (dec),
        .est_maq  (est_maq),
        .disp_en  (disp_en),
        .disp_clk (disp_clk)
    );

    typedef struct {
        int         id;
        logic       chk_dig;
        logic       chk_dclk;
        logic [2:0] gnt;
        logic [1:0] est;
        logic [3:0] dec;
        logic [3:0] unit;
        logic       en;
        logic       dclk;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_id  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected owner view with digit check
    function automatic exp_t E(input logic [2:0] g, input logic [1:0] es,
                               input logic [3:0] d, input logic [3:0] u, input logic en);
        exp_t e;
        e.id = 0; e.chk_dig = 1'b1; e.chk_dclk = 1'b0;
        e.gnt = g; e.est = es; e.dec = d; e.unit = u; e.en = en; e.dclk = 1'b0;
        return e;
    endfunction

    // Blank/idle view: no owner, digits not checked
    function automatic exp_t EB();
        exp_t e;
        e = E(3'b000, 2'd0, 4'd0, 4'd0, 1'b0);
        e.chk_dig = 1'b0;
        return e;
    endfunction

    // All-zero outputs with a scan clock value
    function automatic exp_t ED(input logic dc);
        exp_t e;
        e = E(3'b000, 2'd0, 4'd0, 4'd0, 1'b0);
        e.chk_dclk = 1'b1;
        e.dclk = dc;
        return e;
    endfunction

    task automatic step(input logic rn, input logic [2:0] rq, input logic [23:0] d, input exp_t e);
        @(negedge clk);
        rst_n   = rn;
        req     = rq;
        data_in = d;
        e.id    = step_id;
        step_id++;
        sb.push_back(e);
    endtask

    task automatic do_reset(input logic [2:0] rq, input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, rq, 24'h000000, ED(1'b0));
    endtask

    task automatic chk(input int id, input string name, input logic [7:0] got, input logic [7:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL step%0d %s: got %0h expected %0h", id, name, got, expv);
        end
    endtask

    // Monitor: compare the oldest queued expectation 1 time unit after each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.id, "gnt",     {5'd0, gnt},     {5'd0, e.gnt});
                chk(e.id, "est_maq", {6'd0, est_maq}, {6'd0, e.est});
                chk(e.id, "disp_en", {7'd0, disp_en}, {7'd0, e.en});
                if (e.chk_dig) begin
                    chk(e.id, "dec",  {4'd0, dec},  {4'd0, e.dec});
                    chk(e.id, "unit", {4'd0, unit}, {4'd0, e.unit});
                end
                if (e.chk_dclk) chk(e.id, "disp_clk", {7'd0, disp_clk}, {7'd0, e.dclk});
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        req     = 3'b000;
        data_in = 24'h000000;

        // 1: reset, then idle with scan clock toggling every 2 edges
        do_reset(3'b000, 3);
        step(1'b1, 3'b000, 24'h0, ED(1'b0));
        step(1'b1, 3'b000, 24'h0, ED(1'b1));
        step(1'b1, 3'b000, 24'h0, ED(1'b1));
        step(1'b1, 3'b000, 24'h0, ED(1'b0));
        step(1'b1, 3'b000, 24'h0, ED(1'b0));
        step(1'b1, 3'b000, 24'h0, ED(1'b1));
        step(1'b1, 3'b000, 24'h0, ED(1'b1));
        step(1'b1, 3'b000, 24'h0, ED(1'b0));

        // 2: single requester keeps the display across dwell expiries
        for (int i = 0; i < 20; i++)
            step(1'b1, 3'b001, 24'h000042, E(3'b001, 2'd1, 4'd4, 4'd2, 1'b1));
        step(1'b1, 3'b001, 24'h000037, E(3'b001, 2'd1, 4'd3, 4'd7, 1'b1));
        step(1'b1, 3'b001, 24'h000037, E(3'b001, 2'd1, 4'd3, 4'd7, 1'b1));

        // 3: sources 0 and 2 alternate with 2-cycle blanks
        do_reset(3'b000, 1);
        for (int i = 0; i < 4; i++) step(1'b1, 3'b101, 24'h590011, E(3'b001, 2'd1, 4'd1, 4'd1, 1'b1));
        for (int i = 0; i < 2; i++) step(1'b1, 3'b101, 24'h590011, EB());
        for (int i = 0; i < 4; i++) step(1'b1, 3'b101, 24'h590011, E(3'b100, 2'd3, 4'd5, 4'd9, 1'b1));
        for (int i = 0; i < 2; i++) step(1'b1, 3'b101, 24'h590011, EB());
        for (int i = 0; i < 2; i++) step(1'b1, 3'b101, 24'h590011, E(3'b001, 2'd1, 4'd1, 4'd1, 1'b1));

        // 4: one-cycle request keeps full dwell with frozen digits, then idle holds digits
        do_reset(3'b000, 1);
        step(1'b1, 3'b010, 24'h001500, E(3'b010, 2'd2, 4'd1, 4'd5, 1'b1));
        for (int i = 0; i < 3; i++) step(1'b1, 3'b000, 24'h009900, E(3'b010, 2'd2, 4'd1, 4'd5, 1'b1));
        for (int i = 0; i < 2; i++) step(1'b1, 3'b000, 24'h009900, E(3'b000, 2'd0, 4'd1, 4'd5, 1'b0));

        // 5: reset in the middle of SHOW, then all three request; source 0 first
        do_reset(3'b000, 1);
        step(1'b1, 3'b001, 24'h000042, E(3'b001, 2'd1, 4'd4, 4'd2, 1'b1));
        step(1'b0, 3'b111, 24'h332211, ED(1'b0));
        for (int i = 0; i < 4; i++) step(1'b1, 3'b111, 24'h332211, E(3'b001, 2'd1, 4'd1, 4'd1, 1'b1));
        for (int i = 0; i < 2; i++) step(1'b1, 3'b111, 24'h332211, EB());
        step(1'b1, 3'b111, 24'h332211, E(3'b010, 2'd2, 4'd2, 4'd2, 1'b1));

        // 6: all requests drop during BLANK: blank completes, then idle
        do_reset(3'b000, 1);
        for (int i = 0; i < 4; i++) step(1'b1, 3'b101, 24'h590011, E(3'b001, 2'd1, 4'd1, 4'd1, 1'b1));
        step(1'b1, 3'b101, 24'h590011, EB());
        step(1'b1, 3'b000, 24'h590011, EB());
        step(1'b1, 3'b000, 24'h590011, EB());
        step(1'b1, 3'b000, 24'h590011, EB());

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: pending=%0d expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
